// File: rtl/audio_capture_pkg.sv
// Shared audio definitions: default sample rate and memory geometry, the
// sound-clip windows in the shared sound RAM, and the capture state encoding.
package audio_capture_pkg;

  localparam int AUD_CLK_DIV = 1200;
  localparam int AUD_ADDR_W  = 18;
  localparam int AUD_DATA_W  = 6;

  // Clip windows in sound-RAM words at 41.667 kHz, roughly one second each
  localparam logic [AUD_ADDR_W-1:0] WIN_START    = 18'd0;
  localparam logic [AUD_ADDR_W-1:0] WIN_END      = 18'd41666;
  localparam logic [AUD_ADDR_W-1:0] MOO_START    = 18'd41667;
  localparam logic [AUD_ADDR_W-1:0] MOO_END      = 18'd83333;
  localparam logic [AUD_ADDR_W-1:0] DETECT_START = 18'd83334;
  localparam logic [AUD_ADDR_W-1:0] DETECT_END   = 18'd124999;
  localparam logic [AUD_ADDR_W-1:0] CHEER_START  = 18'd125000;
  localparam logic [AUD_ADDR_W-1:0] CHEER_END    = 18'd166666;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_RECORD = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/audio_capture_sample_tick.sv
// Clock-enable generator: pulses tick once every CLK_DIV enabled cycles.
// clr restarts the count so a new capture begins on a full sample period.
module sample_tick #(
  parameter int CLK_DIV = 1200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/audio_capture.sv
// Microphone capture: drains the codec input FIFO and writes the top DATA_W
// bits of the latest left sample into a sound-RAM window at the playback rate.
module audio_capture
  import audio_capture_pkg::*;
#(
  parameter int CLK_DIV = AUD_CLK_DIV,
  parameter int ADDR_W  = AUD_ADDR_W,
  parameter int DATA_W  = AUD_DATA_W
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] clip_start,
  input  logic [ADDR_W-1:0] clip_end,
  input  logic              audio_in_available,
  input  logic [31:0]       left_channel_audio_in,
  output logic              read_audio_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              bad_window
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] lo_q, lo_d;
  logic [ADDR_W-1:0] hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              bad_q, bad_d;
  logic              have_q, have_d;
  logic [31:0]       sample_q, sample_d;

  logic start_ok;
  logic start_bad;
  logic wr_tick;
  logic at_last;
  logic sample_unused;

  assign start_ok  = start && (state_q == ST_IDLE) && (clip_end >= clip_start);
  assign start_bad = start && (state_q == ST_IDLE) && (clip_end < clip_start);
  assign at_last   = (addr_q == hi_q);

  sample_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .clr   (start_ok),
    .en    (state_q == ST_RECORD),
    .tick  (wr_tick)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A write tick and stop in the same cycle: the write still happens this cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = start_ok ? ST_ARM : ST_IDLE;
      ST_ARM: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (have_q) begin
          state_d = ST_RECORD;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_RECORD: begin
        if (stop || (wr_tick && at_last)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RECORD;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_wren = 1'b0;
    case (state_q)
      ST_IDLE:   busy = 1'b0;
      ST_ARM:    busy = 1'b1;
      ST_RECORD: begin
        busy     = 1'b1;
        mem_wren = wr_tick;
      end
      ST_DONE:   done = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  always_comb begin
    lo_d     = lo_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    bad_d    = bad_q;
    have_d   = have_q;
    sample_d = sample_q;
    if (start_ok) begin
      lo_d   = clip_start;
      hi_d   = clip_end;
      addr_d = clip_start;
      bad_d  = 1'b0;
    end else if (start_bad) begin
      bad_d = 1'b1;
    end else if (mem_wren && !at_last && (addr_q >= lo_q) && (addr_q < hi_q)) begin
      addr_d = addr_q + ADDR_W'(1);
    end else begin
      addr_d = addr_q;
    end
    // Without a fresh pop the previous sample is simply written again
    if (audio_in_available) begin
      sample_d = left_channel_audio_in;
      have_d   = 1'b1;
    end else begin
      sample_d = sample_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      lo_q     <= '0;
      hi_q     <= '0;
      addr_q   <= '0;
      bad_q    <= 1'b0;
      have_q   <= 1'b0;
      sample_q <= 32'd0;
    end else begin
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      addr_q   <= addr_d;
      bad_q    <= bad_d;
      have_q   <= have_d;
      sample_q <= sample_d;
    end
  end

  assign read_audio_in = audio_in_available;
  assign mem_addr      = addr_q;
  assign mem_data      = sample_q[31 -: DATA_W];
  assign bad_window    = bad_q;
  assign sample_unused = ^sample_q[31-DATA_W:0];

endmodule

// File: tb/tb_audio_capture.sv
// Directed bench for audio_capture: a write-list scoreboard plus a held-sample
// model checked every cycle, with literal expectations for each scenario.
module tb_audio_capture;

  localparam int CLK_DIV = 4;
  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 6;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start, stop;
  logic [ADDR_W-1:0] clip_start, clip_end;
  logic              audio_in_available;
  logic [31:0]       left_channel_audio_in;
  logic              read_audio_in;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren, busy, done, bad_window;

  always #5 clk = ~clk;

  audio_capture #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLOCK_50              (clk),
    .resetn                (resetn),
    .start                 (start),
    .stop                  (stop),
    .clip_start            (clip_start),
    .clip_end              (clip_end),
    .audio_in_available    (audio_in_available),
    .left_channel_audio_in (left_channel_audio_in),
    .read_audio_in         (read_audio_in),
    .mem_addr              (mem_addr),
    .mem_data              (mem_data),
    .mem_wren              (mem_wren),
    .busy                  (busy),
    .done                  (done),
    .bad_window            (bad_window)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                chk;
  } wr_t;

  wr_t               exp_q[$];
  int                n_checks = 0;
  int                n_pass = 0;
  int                done_seen = 0;
  int                cyc = 0;
  int                last_wr = -1;
  logic [31:0]       held = 32'd0;
  logic [ADDR_W-1:0] win_lo = '0;
  logic [ADDR_W-1:0] win_hi = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: the written word is the top bits of the most recently popped sample
  always @(negedge clk) begin
    if (!resetn) begin
      held    = 32'd0;
      last_wr = -1;
    end else begin
      wr_t e;
      cyc++;
      check("read_passthru", read_audio_in, audio_in_available);
      if (busy) check("addr_in_window", (mem_addr >= win_lo) && (mem_addr <= win_hi), 1);
      if (mem_wren) begin
        if (exp_q.size() == 0) begin
          check("spurious_write", mem_wren, 0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", mem_addr, e.addr);
          check("write_data_model", mem_data, held[31 -: DATA_W]);
          if (e.chk) check("write_data_literal", mem_data, e.data);
          if (last_wr >= 0) check("write_spacing", cyc - last_wr, CLK_DIV);
          last_wr = cyc;
        end
      end
      if (done) done_seen++;
      if (audio_in_available) held = left_channel_audio_in;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input logic [DATA_W-1:0] d, input bit chk);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    e.chk  = chk;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int lo, input int hi);
    win_lo     = ADDR_W'(lo);
    win_hi     = ADDR_W'(hi);
    last_wr    = -1;
    clip_start = ADDR_W'(lo);
    clip_end   = ADDR_W'(hi);
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_wren();
    for (int i = 0; i < 100 && !mem_wren; i++) step();
    check("wren_seen", mem_wren, 1);
  endtask

  task automatic finish_scn(input string name, input int d0);
    for (int i = 0; i < 200 && done_seen == d0; i++) step();
    repeat (3) step();
    check({name, "_done_once"}, done_seen - d0, 1);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_all_written"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int d0;
    resetn = 1'b0; start = 1'b0; stop = 1'b0;
    clip_start = '0; clip_end = '0;
    audio_in_available = 1'b0; left_channel_audio_in = 32'd0;
    #1;
    check("reset_outputs", {mem_addr, mem_data, mem_wren, busy, done, bad_window}, 0);
    repeat (2) step();
    resetn = 1'b1;
    step();

    // Basic window, pops every cycle
    audio_in_available = 1'b1; left_channel_audio_in = 32'hFC00_0000;
    step();
    d0 = done_seen;
    for (int a = 100; a <= 103; a++) push(a, 6'h3F, 1);
    pulse_start(100, 103);
    check("s1_busy", busy, 1);
    finish_scn("s1", d0);

    // Rejected window, then a valid one clears the flag
    d0 = done_seen;
    pulse_start(50, 49);
    step();
    check("s2_bad_set", bad_window, 1);
    check("s2_idle", busy, 0);
    push(10, 6'h3F, 1);
    pulse_start(10, 10);
    check("s2_bad_clear", bad_window, 0);
    finish_scn("s2", d0);

    // Stop on the second write tick
    left_channel_audio_in = 32'h4000_0000;
    step();
    d0 = done_seen;
    push(0, 6'h10, 1); push(1, 6'h10, 1);
    pulse_start(0, 9);
    wait_wren();
    repeat (CLK_DIV) step();
    stop = 1'b1;
    check("s3_stop_tick_write", mem_wren, 1);
    step();
    stop = 1'b0;
    check("s3_done_after_stop", done, 1);
    finish_scn("s3", d0);

    // Single pop then FIFO empty: sample is held
    left_channel_audio_in = 32'h8000_0000;
    step();
    audio_in_available = 1'b0;
    step();
    d0 = done_seen;
    for (int a = 0; a <= 2; a++) push(a, 6'h20, 1);
    pulse_start(0, 2);
    finish_scn("s4", d0);

    // Reset mid-capture at address 200
    audio_in_available = 1'b1; left_channel_audio_in = 32'h1234_5678;
    step();
    d0 = done_seen;
    push(198, 6'h04, 1); push(199, 6'h04, 1);
    pulse_start(198, 205);
    wait_wren();
    repeat (CLK_DIV) step();
    step();
    check("s5_addr_200", mem_addr, 200);
    resetn = 1'b0;
    #1;
    check("s5_async_clear", {mem_addr, mem_data, mem_wren, busy, done, bad_window}, 0);
    repeat (3) step();
    check("s5_no_done", done_seen - d0, 0);
    check("s5_partial_writes", exp_q.size(), 0);
    resetn = 1'b1;
    step();
    d0 = done_seen;
    push(0, 6'h04, 1);
    pulse_start(0, 0);
    finish_scn("s5", d0);

    // Stray start during RECORD with changing samples
    d0 = done_seen;
    for (int a = 300; a <= 302; a++) push(a, 6'h00, 0);
    pulse_start(300, 302);
    for (int i = 0; i < 30; i++) begin
      left_channel_audio_in = 32'h9E37_79B9 * (i + 1);
      if (i == 8) begin
        check("s6_busy_at_stray", busy, 1);
        clip_start = 18'd400; clip_end = 18'd410; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    finish_scn("s6", d0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_capture.md
AUDIO_CAPTURE -- requirements
Module: audio_capture

Interface
REQ-001 Parameter CLK_DIV, default 1200, is the number of CLOCK_50 cycles per stored sample (41.667 kHz); it matches the playback rate.
REQ-002 Parameter ADDR_W, default 18, is the sound-memory address width.
REQ-003 Parameter DATA_W, default 6, is the stored sample width, equal to the sound-memory word width.
REQ-004 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to begin a capture.
REQ-007 stop  in  1  single-cycle request to end a capture early.
REQ-008 clip_start  in  ADDR_W  first sound-memory address of the capture window.
REQ-009 clip_end  in  ADDR_W  last sound-memory address of the capture window, inclusive.
REQ-010 audio_in_available  in  1  Audio_Controller has an input sample ready.
REQ-011 left_channel_audio_in  in  32  signed left-channel sample from Audio_Controller.
REQ-012 read_audio_in  out  1  pop strobe to Audio_Controller.
REQ-013 mem_addr  out  ADDR_W  sound-memory write address.
REQ-014 mem_data  out  DATA_W  sound-memory write data.
REQ-015 mem_wren  out  1  sound-memory write enable, one cycle per stored sample.
REQ-016 busy  out  1  high in ARM and RECORD.
REQ-017 done  out  1  single-cycle pulse when a capture ends.
REQ-018 bad_window  out  1  sticky; set when a start is rejected for clip_end < clip_start.

Function
REQ-019 The state machine has four states: IDLE, ARM, RECORD and DONE.
REQ-020 In IDLE, start with clip_end >= clip_start latches both window bounds, loads mem_addr with clip_start, clears the tick counter, clears bad_window and moves to ARM.
REQ-021 In IDLE, start with clip_end < clip_start sets bad_window and stays in IDLE.
REQ-022 In ARM, the first valid sample (have_sample = 1) moves the machine to RECORD.
REQ-023 A write tick is a tick-counter value of CLK_DIV-1 in RECORD; the counter then wraps to 0.
REQ-024 On each write tick, mem_wren = 1 for one cycle, mem_data = latched sample[31:32-DATA_W] (top bits, two's complement, no rounding), and mem_addr holds the address being written.
REQ-025 After a write tick at an address below clip_end, mem_addr increments by 1.
REQ-026 A write tick at mem_addr == clip_end moves the machine to DONE and mem_addr does not increment.
REQ-027 stop in ARM or RECORD moves the machine to DONE without writing.
REQ-028 If stop and a write tick occur in the same cycle, the write completes, then the machine moves to DONE.
REQ-029 DONE lasts one cycle, asserts done, and returns to IDLE.
REQ-030 start while busy or in DONE is ignored.
REQ-031 read_audio_in = audio_in_available in every state (FIFO always drained, combinational).
REQ-032 Each pop latches left_channel_audio_in into the sample register and sets have_sample.
REQ-033 A write tick with no new pop since the previous tick rewrites the last latched sample (hold, no underflow flag).
REQ-034 mem_wren is never high outside RECORD, and mem_addr never leaves the latched window.
REQ-035 A single-sample window (clip_end == clip_start) produces exactly one write.

Reset
REQ-036 When resetn = 0 the block asynchronously sets: state IDLE, mem_addr 0, mem_data 0, mem_wren 0, done 0, busy 0, bad_window 0, have_sample 0, tick counter 0, sample register 0.
REQ-037 Reset during RECORD aborts the capture with no done pulse; the partial memory contents are left as written.
REQ-038 The first start after reset release is honoured.

Structure
REQ-039 A shared audio package holds the sound-window constants (win, moo, detect, cheer start/end), CLK_DIV, ADDR_W, DATA_W and the state enumeration.
REQ-040 The divider is one sub-module, sample_tick, a CLK_DIV clock-enable generator with a synchronous clear; all other logic is in audio_capture.
REQ-041 The RTL contains no memory; the write port connects externally to the dual-port sound RAM.

Verification
REQ-042 Window 100..103, CLK_DIV=4, pops every cycle with data 0xFC00_0000 -> writes at addresses 100,101,102,103 with data 6'h3F, done pulses once, busy falls.
REQ-043 start with clip_start=50, clip_end=49 -> bad_window=1, state IDLE, no mem_wren; a following valid start clears bad_window.
REQ-044 stop asserted on the cycle of the 2nd write tick, window 0..9 -> exactly 2 writes (addresses 0 and 1), done pulses in the next cycle.
REQ-045 One pop only (0x8000_0000), then none, window 0..2 -> three writes of 6'h20.
REQ-046 resetn low in mid-RECORD at address 200 -> all outputs zero immediately, no done pulse; a new start at 0..0 -> one write at address 0.
REQ-047 start pulsed during RECORD with a different window -> ignored; the original window completes.
